// File: rtl/awb_gain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : awb_gain_ctrl_pkg
// Description : Shared types and constants for the gray-world AWB controller.
// Revision    : 1.0 - initial release
// ============================================================================
package awb_gain_ctrl_pkg;

    localparam logic [1:0] CFA_RGGB = 2'b00;
    localparam logic [1:0] CFA_GRBG = 2'b01;
    localparam logic [1:0] CFA_GBRG = 2'b10;
    localparam logic [1:0] CFA_BGGR = 2'b11;

    localparam logic [7:0] GAIN_UNITY = 8'h80;
    localparam logic [7:0] GAIN_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } awb_ch_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_R  = 2'd1,
        DIV_B  = 2'd2,
        UPDATE = 2'd3
    } awb_state_t;

    // Row 0 / column 0 always carries the first letter pair of the pattern name.
    function automatic awb_ch_t cfa_channel(input logic [1:0] pattern,
                                            input logic       v_odd,
                                            input logic       h_odd);
        awb_ch_t ch;
        ch = CH_G;
        case (pattern)
            CFA_RGGB: begin
                if (!v_odd && !h_odd)     ch = CH_R;
                else if (v_odd && h_odd)  ch = CH_B;
            end
            CFA_GRBG: begin
                if (!v_odd && h_odd)      ch = CH_R;
                else if (v_odd && !h_odd) ch = CH_B;
            end
            CFA_GBRG: begin
                if (!v_odd && h_odd)      ch = CH_B;
                else if (v_odd && !h_odd) ch = CH_R;
            end
            default: begin
                if (!v_odd && !h_odd)     ch = CH_B;
                else if (v_odd && h_odd)  ch = CH_R;
            end
        endcase
        return ch;
    endfunction

    function automatic logic [7:0] gain_smooth(input logic [7:0] old_gain,
                                               input logic [7:0] new_gain);
        logic [9:0] mix;
        mix = ({2'b00, old_gain} << 1) + {2'b00, old_gain} + {2'b00, new_gain};
        return mix[9:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/awb_div.sv
`default_nettype none
// ============================================================================
// Module      : awb_div
// Description : 9-cycle serial restoring divider, 8-bit quotient saturating at 0xFF.
// Revision    : 1.0 - initial release
// ============================================================================
module awb_div
    import awb_gain_ctrl_pkg::*;
#(
    parameter int ACC_W = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ACC_W+5:0]   num,
    input  logic [ACC_W-1:0]   den,
    output logic               done,
    output logic [7:0]         q
);

    localparam int REM_W = ACC_W + 8;

    logic [REM_W-1:0] r_rem;
    logic [ACC_W-1:0] r_den;
    logic [2:0]       r_step;
    logic             r_run;
    logic             r_sat;
    logic [7:0]       r_q;

    logic [REM_W-1:0] w_num_ext;
    logic [REM_W-1:0] w_den_sh8;
    logic             w_sat;
    logic [2:0]       w_bit;
    logic [REM_W-1:0] w_trial;
    logic             w_ge;

    assign w_num_ext = {2'b00, num};
    assign w_den_sh8 = {den, 8'h00};
    assign w_sat     = (den == '0) || (w_num_ext >= w_den_sh8);
    assign w_bit     = 3'd7 - r_step;
    assign w_trial   = {8'h00, r_den} << w_bit;
    assign w_ge      = (r_rem >= w_trial);

    // Start edge is the saturation check; the following eight edges each
    // resolve one quotient bit even when saturated, so latency is fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_step <= 3'd0;
            r_run  <= 1'b0;
            r_sat  <= 1'b0;
            r_q    <= 8'h00;
        end else if (start) begin
            r_rem  <= w_num_ext;
            r_den  <= den;
            r_step <= 3'd0;
            r_run  <= 1'b1;
            r_sat  <= w_sat;
            r_q    <= w_sat ? GAIN_MAX : 8'h00;
        end else if (r_run) begin
            if (!r_sat && w_ge) begin
                r_rem      <= r_rem - w_trial;
                r_q[w_bit] <= 1'b1;
            end
            r_step <= r_step + 3'd1;
            if (r_step == 3'd7) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done = r_run && (r_step == 3'd7);
    assign q    = r_q;

endmodule
`default_nettype wire

// File: rtl/awb_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : awb_gain_ctrl
// Description : Gray-world AWB controller; per-frame R/G/B sums -> R/B gains.
//               Define AWB_SMOOTH_EN for temporal (3*old+new)/4 gain smoothing.
// Revision    : 1.0 - initial release
// ============================================================================
module awb_gain_ctrl
    import awb_gain_ctrl_pkg::*;
#(
    parameter int         ACC_W  = 30,
    parameter logic [7:0] SAT_TH = 8'd250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clken,
    input  logic [7:0]  din,
    input  logic [1:0]  pattern,
    input  logic [10:0] h_active,
    input  logic [10:0] v_active,
    input  logic        awb_en,
    input  logic [7:0]  man_r_gain,
    input  logic [7:0]  man_g_gain,
    input  logic [7:0]  man_b_gain,
    output logic [7:0]  r_gain,
    output logic [7:0]  g_gain,
    output logic [7:0]  b_gain,
    output logic        gain_valid,
    output logic        busy
);

    logic [10:0]      r_h_cnt;
    logic [10:0]      r_v_cnt;
    logic [ACC_W-1:0] r_sum_r, r_sum_g, r_sum_b;
    logic [ACC_W-1:0] r_snap_r, r_snap_g, r_snap_b;
    awb_state_t       r_state;
    logic             r_start;
    logic [7:0]       r_q_r;
    logic [7:0]       r_gain_r, r_gain_g, r_gain_b;
    logic             r_gain_valid;

    awb_ch_t          w_ch;
    logic             w_take;
    logic [ACC_W-1:0] w_pix;
    logic [ACC_W-1:0] w_next_r, w_next_g, w_next_b;
    logic             w_h_last, w_v_last, w_frame_end;
    logic [ACC_W+5:0] w_num;
    logic [ACC_W-1:0] w_den;
    logic             w_div_done;
    logic [7:0]       w_div_q;
    logic [7:0]       w_new_r, w_new_g, w_new_b;

    assign w_ch        = cfa_channel(pattern, r_v_cnt[0], r_h_cnt[0]);
    assign w_take      = clken && (din < SAT_TH);
    assign w_pix       = {{(ACC_W-8){1'b0}}, din};
    assign w_next_r    = r_sum_r + ((w_take && w_ch == CH_R) ? w_pix : '0);
    assign w_next_g    = r_sum_g + ((w_take && w_ch == CH_G) ? w_pix : '0);
    assign w_next_b    = r_sum_b + ((w_take && w_ch == CH_B) ? w_pix : '0);
    assign w_h_last    = (r_h_cnt == h_active - 11'd1);
    assign w_v_last    = (r_v_cnt == v_active - 11'd1);
    assign w_frame_end = clken && w_h_last && w_v_last;

    // G has twice the samples of R/B, hence <<6 rather than <<7.
    assign w_num = {r_snap_g, 6'b000000};
    assign w_den = (r_state == DIV_B) ? r_snap_b : r_snap_r;

    awb_div #(
        .ACC_W (ACC_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (r_start),
        .num   (w_num),
        .den   (w_den),
        .done  (w_div_done),
        .q     (w_div_q)
    );

`ifdef AWB_SMOOTH_EN
    assign w_new_r = gain_smooth(r_gain_r, r_q_r);
    assign w_new_g = gain_smooth(r_gain_g, GAIN_UNITY);
    assign w_new_b = gain_smooth(r_gain_b, w_div_q);
`else
    assign w_new_r = r_q_r;
    assign w_new_g = GAIN_UNITY;
    assign w_new_b = w_div_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt      <= 11'd0;
            r_v_cnt      <= 11'd0;
            r_sum_r      <= '0;
            r_sum_g      <= '0;
            r_sum_b      <= '0;
            r_snap_r     <= '0;
            r_snap_g     <= '0;
            r_snap_b     <= '0;
            r_state      <= IDLE;
            r_start      <= 1'b0;
            r_q_r        <= 8'h00;
            r_gain_r     <= GAIN_UNITY;
            r_gain_g     <= GAIN_UNITY;
            r_gain_b     <= GAIN_UNITY;
            r_gain_valid <= 1'b0;
        end else begin
            if (clken) begin
                if (w_h_last) begin
                    r_h_cnt <= 11'd0;
                    r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 11'd1;
                end
            end

            if (w_frame_end) begin
                r_sum_r <= '0;
                r_sum_g <= '0;
                r_sum_b <= '0;
                if (r_state == IDLE) begin
                    r_snap_r <= w_next_r;
                    r_snap_g <= w_next_g;
                    r_snap_b <= w_next_b;
                end
            end else begin
                r_sum_r <= w_next_r;
                r_sum_g <= w_next_g;
                r_sum_b <= w_next_b;
            end

            r_start      <= 1'b0;
            r_gain_valid <= 1'b0;

            if (!awb_en) begin
                r_gain_r <= man_r_gain;
                r_gain_g <= man_g_gain;
                r_gain_b <= man_b_gain;
            end

            case (r_state)
                IDLE: begin
                    if (w_frame_end) begin
                        r_state <= DIV_R;
                        r_start <= 1'b1;
                    end
                end
                DIV_R: begin
                    if (w_div_done) begin
                        r_state <= DIV_B;
                        r_start <= 1'b1;
                    end
                end
                DIV_B: begin
                    // Divider still holds the R quotient on the B start edge.
                    if (r_start) begin
                        r_q_r <= w_div_q;
                    end
                    if (w_div_done) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                    if (awb_en) begin
                        r_gain_r     <= w_new_r;
                        r_gain_g     <= w_new_g;
                        r_gain_b     <= w_new_b;
                        r_gain_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r_gain     = r_gain_r;
    assign g_gain     = r_gain_g;
    assign b_gain     = r_gain_b;
    assign gain_valid = r_gain_valid;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_awb_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_awb_gain_ctrl
// Description : Directed self-checking bench for awb_gain_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_awb_gain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clken;
    logic [7:0]  din;
    logic [1:0]  pattern;
    logic [10:0] h_active;
    logic [10:0] v_active;
    logic        awb_en;
    logic [7:0]  man_r_gain, man_g_gain, man_b_gain;
    logic [7:0]  r_gain, g_gain, b_gain;
    logic        gain_valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int npulse;

    always #5 clk = ~clk;

    awb_gain_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clken      (clken),
        .din        (din),
        .pattern    (pattern),
        .h_active   (h_active),
        .v_active   (v_active),
        .awb_en     (awb_en),
        .man_r_gain (man_r_gain),
        .man_g_gain (man_g_gain),
        .man_b_gain (man_b_gain),
        .r_gain     (r_gain),
        .g_gain     (g_gain),
        .b_gain     (b_gain),
        .gain_valid (gain_valid),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [1:0] pat, input int v, input int h,
                                       input logic [7:0] rv, input logic [7:0] gv,
                                       input logic [7:0] bv);
        logic [1:0] pos;
        pos = {v[0], h[0]};
        case (pat)
            2'b00:   return (pos == 2'b00) ? rv : (pos == 2'b11) ? bv : gv;
            2'b01:   return (pos == 2'b01) ? rv : (pos == 2'b10) ? bv : gv;
            2'b10:   return (pos == 2'b10) ? rv : (pos == 2'b01) ? bv : gv;
            default: return (pos == 2'b11) ? rv : (pos == 2'b00) ? bv : gv;
        endcase
    endfunction

    // Entered and left 1 time unit after a rising edge; last pixel on the final edge.
    task automatic send_frame(input logic [1:0] pat, input int hw, input int vw,
                              input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
        pattern  = pat;
        h_active = 11'(hw);
        v_active = 11'(vw);
        for (int v = 0; v < vw; v++) begin
            for (int h = 0; h < hw; h++) begin
                din   = pix(pat, v, h, rv, gv, bv);
                clken = 1'b1;
                @(posedge clk); #1;
            end
        end
        clken = 1'b0;
        din   = 8'h00;
    endtask

    task automatic wait_valid(output int l);
        l = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (gain_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (gain_valid) n++;
        end
    endtask

    task automatic check_gains(input string tag, input logic [7:0] er,
                               input logic [7:0] eg, input logic [7:0] eb);
        check({tag, "_r"}, {24'h0, r_gain}, {24'h0, er});
        check({tag, "_g"}, {24'h0, g_gain}, {24'h0, eg});
        check({tag, "_b"}, {24'h0, b_gain}, {24'h0, eb});
    endtask

    initial begin
        rst_n = 1'b0; clken = 1'b0; din = 8'h00; pattern = 2'b00;
        h_active = 11'd4; v_active = 11'd4; awb_en = 1'b1;
        man_r_gain = 8'h00; man_g_gain = 8'h00; man_b_gain = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_gains("reset", 8'h80, 8'h80, 8'h80);
        check("reset_valid", {31'h0, gain_valid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Gray frame: unity gains, 19-edge latency, single-cycle pulse.
        send_frame(2'b00, 4, 4, 8'd100, 8'd100, 8'd100);
        check("gray_busy", {31'h0, busy}, 32'h1);
        wait_valid(lat);
        check("gray_latency", lat, 32'd19);
        check_gains("gray", 8'h80, 8'h80, 8'h80);
        @(posedge clk); #1;
        check("gray_pulse_end", {31'h0, gain_valid}, 32'h0);
        check("gray_idle", {31'h0, busy}, 32'h0);

        send_frame(2'b00, 4, 4, 8'd200, 8'd100, 8'd100);
        wait_valid(lat);
        check("r200_latency", lat, 32'd19);
        check_gains("r200", 8'h40, 8'h80, 8'h80);

        send_frame(2'b00, 4, 4, 8'd50, 8'd100, 8'd100);
        wait_valid(lat);
        check_gains("r50_sat", 8'hFF, 8'h80, 8'h80);

        send_frame(2'b00, 4, 4, 8'd100, 8'd100, 8'd200);
        wait_valid(lat);
        check_gains("b200", 8'h80, 8'h80, 8'h40);

        send_frame(2'b00, 4, 4, 8'd0, 8'd100, 8'd100);
        wait_valid(lat);
        check_gains("r0_den0", 8'hFF, 8'h80, 8'h80);

        // BGGR with saturated B, then saturated G.
        send_frame(2'b11, 4, 4, 8'd100, 8'd100, 8'd255);
        wait_valid(lat);
        check_gains("bggr_bsat", 8'h80, 8'h80, 8'hFF);

        send_frame(2'b11, 4, 4, 8'd100, 8'd254, 8'd100);
        wait_valid(lat);
        check_gains("bggr_gsat", 8'h00, 8'h80, 8'h00);

        // Manual mode: outputs follow next cycle, no update from a frame.
        awb_en = 1'b0;
        man_r_gain = 8'h11; man_g_gain = 8'h22; man_b_gain = 8'h33;
        @(posedge clk); #1;
        check_gains("manual", 8'h11, 8'h22, 8'h33);
        send_frame(2'b00, 4, 4, 8'd200, 8'd100, 8'd100);
        wait_valid(lat);
        check("manual_no_valid", lat, 32'hFFFF_FFFF);
        check_gains("manual_hold", 8'h11, 8'h22, 8'h33);

        awb_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_gains("auto_keep_manual", 8'h11, 8'h22, 8'h33);

        // Second frame end while busy is dropped.
        send_frame(2'b00, 4, 4, 8'd200, 8'd100, 8'd100);
        send_frame(2'b00, 2, 2, 8'd100, 8'd100, 8'd100);
        count_valid(40, npulse);
        check("drop_pulses", npulse, 32'd1);
        check_gains("drop", 8'h40, 8'h80, 8'h80);

        // Reset during DIV_B, then a clean frame.
        send_frame(2'b00, 4, 4, 8'd100, 8'd100, 8'd200);
        repeat (12) @(posedge clk);
        #1;
        check("midreset_busy_before", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_gains("midreset", 8'h80, 8'h80, 8'h80);
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_valid", {31'h0, gain_valid}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(2'b00, 4, 4, 8'd50, 8'd100, 8'd200);
        wait_valid(lat);
        check("post_reset_latency", lat, 32'd19);
        check_gains("post_reset", 8'hFF, 8'h80, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/awb_gain_ctrl.md
Name: awb_gain_ctrl

Overview:
- Gray-world auto-white-balance controller for the Bayer colour-gain stage.
- Accumulates per-channel R/G/B sums over each raw frame.
- At frame end, computes R and B gains relative to G using a shared serial divider.
- Drives r/g/b gain inputs of the gain datapath (U1.7 format: 0x80 = 1.0x, max 0xFF ≈ 1.99x).
- Tap is parallel to the datapath input (same clk/clken/din); adds no pixel latency.

Parameters:
- ACC_W, 30, channel accumulator width (supports 2048x2048 frames at 8 bit).
- SAT_TH, 8'd250, pixels >= SAT_TH are excluded from accumulation.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clken  in  1  pixel valid strobe
- din  in  8  raw Bayer pixel
- pattern  in  2  CFA code: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR
- h_active  in  11  active pixels per line
- v_active  in  11  active lines per frame
- awb_en  in  1  1 = auto gains, 0 = manual gains
- man_r_gain / man_g_gain / man_b_gain  in  8 each  manual gains
- r_gain / g_gain / b_gain  out  8 each  gains to datapath
- gain_valid  out  1  one-cycle pulse when new auto gains are loaded
- busy  out  1  high while the divider FSM is not IDLE

Behaviour:
- Reset values: r_gain = g_gain = b_gain = 0x80; gain_valid = 0; busy = 0; counters, sums and FSM cleared (IDLE).
- h_cnt / v_cnt advance on clken exactly as in the gain datapath: wrap h at h_active-1, increment v on h wrap, wrap v at v_active-1.
- Channel of a pixel = f(pattern, v_cnt[0], h_cnt[0]); row 0 starts the pattern. Example, RGGB: (0,0)=R, (0,1)=G, (1,0)=G, (1,1)=B.
- On clken with din < SAT_TH: add din to that channel's sum (unsigned, ACC_W bits, no overflow check required within the frame limit).
- Frame end = clken with h_cnt = h_active-1 and v_cnt = v_active-1. On that edge:
  - Snapshot sums, including the current pixel, into divider operand registers.
  - Clear the accumulators.
  - FSM IDLE -> DIV_R.
  - If the FSM is not IDLE at frame end, discard the snapshot, still clear the accumulators, and keep the FSM running.
- Gain computation:
  - Numerator = Gsum << 6 (G has twice the samples: gain = 128 · (Gsum/2) / Rsum).
  - DIV_R: 9 cycles.
    - Cycle 1 (saturation check): if den == 0 or num >= den << 8, then q = 0xFF.
    - Otherwise cycles 2-9 perform restoring division, one quotient bit per cycle, MSB first, giving q = floor(num/den).
  - DIV_B: identical, using Bsum.
  - UPDATE: 1 cycle. Registers r_gain = qR, b_gain = qB, g_gain = 0x80; pulses gain_valid; then -> IDLE.
- Latency: with the last pixel sampled on edge 0, gains change and gain_valid is high after edge 19.
- awb_en = 0:
  - Outputs register man_* every cycle.
  - Accumulation and FSM keep running, but UPDATE does not load outputs or pulse gain_valid.
- awb_en 0 -> 1: outputs keep manual values until the next UPDATE.
- rst_n asserted mid-division: FSM and all state return to reset values immediately; the partial result is lost.
- h_active / v_active / pattern are static during a frame; changing them mid-frame gives undefined sums but must not hang the FSM.

Optional Feature:
- AWB_SMOOTH_EN defined: UPDATE loads new = (3·old + q) >> 2 per channel, using a 10-bit intermediate, truncated. Convergence is temporal.
- AWB_SMOOTH_EN undefined: UPDATE loads q directly.

Decomposition:
- Shared package holds:
  - CFA pattern codes and channel enum (CH_R, CH_G, CH_B).
  - GAIN_UNITY = 8'h80 and GAIN_MAX = 8'hFF.
  - FSM state encoding (IDLE, DIV_R, DIV_B, UPDATE).
- Sub-module awb_div: serial restoring divider.
  - Inputs: start, num[ACC_W+6], den[ACC_W].
  - Outputs: done, q[8], with built-in saturation.
  - Reused for both channels.

Test Plan:
- 4x4 RGGB, all pixels 100, awb_en=1 -> gain_valid 19 cycles after the last pixel; r/g/b = 0x80/0x80/0x80.
- Same frame, R pixels 200 -> Rsum 800, r_gain = 0x40; b_gain 0x80.
- R pixels 50 -> num 51200 = den<<8 -> r_gain saturates 0xFF; R pixels 0 (den = 0) -> r_gain 0xFF.
- Pattern BGGR, B pixels 255 with SAT_TH=250 -> B excluded, Bsum = 0 -> b_gain 0xFF; G pixels 254 also excluded -> Gsum = 0 -> r_gain 0x00.
- awb_en=0, man gains 0x11/0x22/0x33 -> outputs follow next cycle, no gain_valid; second frame end while busy (2x2 frame) -> snapshot dropped, single gain_valid.
- rst_n pulse during DIV_B -> outputs 0x80, busy 0 immediately; the next full frame computes correctly. With AWB_SMOOTH_EN, old 0x80 and q 0x40 -> 0x70.
